// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: push request in, storage strobe/address,
// write pointers and occupancy flags out.
interface fifo_wr_ctrl_if #(
  parameter int PtrWidth = 2
);
  // Handshake: i_push carries no ready; a push is taken exactly in the cycle
  // where o_wr_en (= i_push & ~o_full) is high, and the word is written at
  // that rising edge. A push seen while o_full is high is dropped and flagged.
  logic                i_push;
  logic [PtrWidth:0]   i_rd_gray_ptr_sync;
  logic                i_clr_overflow;
  logic                o_wr_en;
  logic [PtrWidth-1:0] o_wr_addr;
  logic [PtrWidth:0]   o_wr_bin_ptr;
  logic [PtrWidth:0]   o_wr_gray_ptr;
  logic                o_full;
  logic                o_almost_full;
  logic [PtrWidth:0]   o_level;
  logic                o_overflow;

  modport master (
    output i_push, i_rd_gray_ptr_sync, i_clr_overflow,
    input  o_wr_en, o_wr_addr, o_wr_bin_ptr, o_wr_gray_ptr,
           o_full, o_almost_full, o_level, o_overflow
  );

  modport slave (
    input  i_push, i_rd_gray_ptr_sync, i_clr_overflow,
    output o_wr_en, o_wr_addr, o_wr_bin_ptr, o_wr_gray_ptr,
           o_full, o_almost_full, o_level, o_overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: binary/Gray write pointers,
// lookahead full, fill level, almost-full and sticky overflow.
module fifo_wr_ctrl #(
  parameter int PtrWidth      = 2,
  parameter int AlmostFullThr = 3
) (
  input logic           clk,
  input logic           rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam logic [PtrWidth:0] ThrVal = (PtrWidth+1)'(AlmostFullThr);

  function automatic logic [PtrWidth:0] gray2bin(input logic [PtrWidth:0] g);
    logic [PtrWidth:0] b;
    b = '0;
    for (int i = 0; i <= PtrWidth; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [PtrWidth:0] r_wr_bin_ptr;
  logic [PtrWidth:0] r_wr_gray_ptr;
  logic [PtrWidth:0] r_level;
  logic              r_full;
  logic              r_almost_full;
  logic              r_overflow;

  logic [PtrWidth:0] w_rd_bin;
  logic              w_accept;
  logic [PtrWidth:0] w_wr_next;
  logic [PtrWidth:0] w_level_next;
  logic              w_full_next;
  logic              w_overflow_next;

  always_comb begin
    w_rd_bin     = gray2bin(bus.i_rd_gray_ptr_sync);
    w_accept     = bus.i_push & ~r_full;
    w_wr_next    = r_wr_bin_ptr + {{PtrWidth{1'b0}}, w_accept};
    w_level_next = w_wr_next - w_rd_bin;
    // Full when the pointers differ only in the wrap bit.
    w_full_next  = (w_wr_next[PtrWidth] != w_rd_bin[PtrWidth]) &&
                   (w_wr_next[PtrWidth-1:0] == w_rd_bin[PtrWidth-1:0]);
    if (bus.i_push && r_full) begin
      w_overflow_next = 1'b1;
    end else if (bus.i_clr_overflow) begin
      w_overflow_next = 1'b0;
    end else begin
      w_overflow_next = r_overflow;
    end
  end

  // Gray pointer derives from w_wr_next so it always matches r_wr_bin_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bin_ptr  <= '0;
      r_wr_gray_ptr <= '0;
      r_level       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_bin_ptr  <= w_wr_next;
      r_wr_gray_ptr <= w_wr_next ^ (w_wr_next >> 1);
      r_level       <= w_level_next;
      r_full        <= w_full_next;
      r_almost_full <= (w_level_next >= ThrVal);
      r_overflow    <= w_overflow_next;
    end
  end

  assign bus.o_wr_en       = w_accept;
  assign bus.o_wr_addr     = r_wr_bin_ptr[PtrWidth-1:0];
  assign bus.o_wr_bin_ptr  = r_wr_bin_ptr;
  assign bus.o_wr_gray_ptr = r_wr_gray_ptr;
  assign bus.o_full        = r_full;
  assign bus.o_almost_full = r_almost_full;
  assign bus.o_level       = r_level;
  assign bus.o_overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: two instances (almost-full thresholds 3 and 1) share
// stimulus and are checked against a counting model of the write side.
module tb_fifo_wr_ctrl;
  localparam int PW    = 2;
  localparam int DEPTH = 4;
  localparam int MOD   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        clr = 1'b0;
  logic [PW:0] rd_g = '0;

  int total = 0;
  int bad   = 0;

  // model: words accepted so far and words read so far, as plain counts
  int m_wr;
  int rd_cnt;
  int m_level;
  bit m_full;
  bit m_ovf;

  fifo_wr_ctrl_if #(.PtrWidth(PW)) bus3 ();
  fifo_wr_ctrl_if #(.PtrWidth(PW)) bus1 ();

  assign bus3.i_push = push;
  assign bus3.i_rd_gray_ptr_sync = rd_g;
  assign bus3.i_clr_overflow = clr;
  assign bus1.i_push = push;
  assign bus1.i_rd_gray_ptr_sync = rd_g;
  assign bus1.i_clr_overflow = clr;

  fifo_wr_ctrl #(.PtrWidth(PW), .AlmostFullThr(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  fifo_wr_ctrl #(.PtrWidth(PW), .AlmostFullThr(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic int gray_of(input int n);
    int b;
    b = n % MOD;
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; rd_cnt = 0; m_level = 0; m_full = 0; m_ovf = 0;
  endtask

  task automatic chk_regs(input string ph);
    chk({ph, "_bin"},  32'(bus3.o_wr_bin_ptr), 32'(m_wr % MOD));
    chk({ph, "_gray"}, 32'(bus3.o_wr_gray_ptr), 32'(gray_of(m_wr)));
    chk({ph, "_lvl"},  32'(bus3.o_level), 32'(m_level));
    chk({ph, "_full"}, 32'(bus3.o_full), 32'(m_full));
    chk({ph, "_af3"},  32'(bus3.o_almost_full), 32'(m_level >= 3));
    chk({ph, "_af1"},  32'(bus1.o_almost_full), 32'(m_level >= 1));
    chk({ph, "_ovf"},  32'(bus3.o_overflow), 32'(m_ovf));
    chk({ph, "_lvl1"}, 32'(bus1.o_level), 32'(m_level));
  endtask

  // One cycle from negedge to negedge: drive, check the strobe, clock, check state.
  task automatic cycle(input string ph, input bit p, input int rd, input bit c);
    bit acc;
    push = p; clr = c; rd_cnt = rd; rd_g = PW'(0) | (PW+1)'(gray_of(rd));
    #1;
    acc = p && !m_full;
    chk({ph, "_wren"}, 32'(bus3.o_wr_en), 32'(acc));
    if (acc) chk({ph, "_addr"}, 32'(bus3.o_wr_addr), 32'(m_wr % DEPTH));
    @(posedge clk);
    if (p && m_full) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (acc) m_wr++;
    m_level = (m_wr - rd_cnt) % MOD;
    m_full  = (m_level == DEPTH);
    #1;
    chk_regs(ph);
    @(negedge clk);
  endtask

  initial begin
    int prev_g;
    model_reset();
    rst = 1'b1;
    #1;
    chk_regs("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // a couple of pushes, then reset in the middle of a cycle with push held
    cycle("pre", 1, 0, 0);
    cycle("pre", 1, 0, 0);
    push = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_regs("mrst");
    push = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // fill to full; first push after reset lands at address 0
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, 0);
    chk("fill_bin4",  32'(bus3.o_wr_bin_ptr), 32'd4);
    chk("fill_gray6", 32'(bus3.o_wr_gray_ptr), 32'd6);

    // overflow: refused push, set beats clear, then clear alone
    cycle("ovf_set", 1, 0, 0);
    cycle("ovf_setclr", 1, 0, 1);
    cycle("ovf_clr", 0, 0, 1);

    // release one slot, then the push taken next cycle refills
    cycle("rel", 0, 1, 0);
    cycle("rel_push", 1, 1, 0);

    // wrap: read pointer trails the write pointer by one
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("wrap0", 1, 0, 0);
    prev_g = gray_of(m_wr);
    for (int i = 0; i < 20; i++) begin
      cycle("wrap", 1, m_wr, 0);
      chk("wrap_gstep", 32'($countones(bus3.o_wr_gray_ptr ^ (PW+1)'(prev_g))), 32'd1);
      prev_g = gray_of(m_wr);
    end
    cycle("catchup", 0, m_wr, 0);

    // random traffic; read side never passes the write side
    for (int i = 0; i < 400; i++) begin
      int rd;
      rd = rd_cnt;
      if (rd < m_wr && $urandom_range(0, 99) < 45) rd = rd + $urandom_range(1, m_wr - rd);
      cycle("rnd", ($urandom_range(0, 99) < 65), rd, ($urandom_range(0, 99) < 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
